// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
// Upstream stage of a 4-bit HD44780 nibble interface. Holds a 2-row character
// frame buffer, runs the LCD power-up command sequence, then streams the whole
// buffer to the display each time it changes.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   wr_valid/ready  character write port (wr_char, 0x0A = newline)
//   clear           one-cycle pulse: blank the buffer and home the cursor
//   lcd_req/ack     byte handshake to the nibble writer (lcd_rs, lcd_byte)
//   init_done       power-up command sequence complete
//   busy            init, clear fill or refresh in progress
module lcd_text_sequencer #(
  parameter int COLS       = 16,
  parameter int INIT_DELAY = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clear,
  output logic       lcd_req,
  output logic       lcd_rs,
  output logic [7:0] lcd_byte,
  input  logic       lcd_ack,
  output logic       init_done,
  output logic       busy
);

  localparam int DEPTH = 2 * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNTW  = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   COLS_A    = AW'(COLS);
  localparam logic [AW-1:0]   LAST_COL  = AW'(COLS - 1);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(INIT_DELAY - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_IDLE     = 3'd2,
    S_ROW_CMD  = 3'd3,
    S_DATA     = 3'd4
  } state_e;

  // HD44780 4-bit power-up command list.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h02;
      3'd1:    init_cmd = 8'h28;
      3'd2:    init_cmd = 8'h0C;
      3'd3:    init_cmd = 8'h01;
      3'd4:    init_cmd = 8'h06;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          fill_active_q, fill_active_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          dirty_q, dirty_d;
  logic          wr_ready_q, wr_ready_d;
  state_e        state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          lcd_req_q, lcd_req_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_byte_q, lcd_byte_d;
  logic          init_done_q, init_done_d;
  logic          busy_q, busy_d;

  logic          wr_accept_s;
  logic          refresh_start_s;
  logic [AW-1:0] rd_addr_s;

  // clear must block a same-cycle write, so it gates the registered ready.
  assign wr_ready    = wr_ready_q & ~clear;
  assign wr_accept_s = wr_valid & wr_ready;
  assign rd_addr_s   = row_q ? (COLS_A + col_q) : col_q;

  assign lcd_req   = lcd_req_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_byte  = lcd_byte_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

  // Buffer write path: clear fill, character writes, cursor and dirty flag.
  always_comb begin
    mem_d         = mem_q;
    fill_active_d = fill_active_q;
    fill_addr_d   = fill_addr_q;
    cursor_d      = cursor_q;
    if (refresh_start_s) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end

    if (fill_active_q) begin
      mem_d[fill_addr_q] = 8'h20;
      if (fill_addr_q == LAST_ADDR) begin
        fill_active_d = 1'b0;
        fill_addr_d   = '0;
        cursor_d      = '0;
        dirty_d       = 1'b1;
      end else begin
        fill_addr_d = fill_addr_q + AW'(1);
      end
    end else if (wr_accept_s) begin
      if (wr_char == 8'h0A) begin
        cursor_d = (cursor_q < COLS_A) ? COLS_A : '0;
      end else begin
        mem_d[cursor_q] = wr_char;
        cursor_d        = (cursor_q == LAST_ADDR) ? '0 : (cursor_q + AW'(1));
        dirty_d         = 1'b1;
      end
    end else begin
      cursor_d = cursor_q;
    end

    // A clear pulse (re)starts the fill from address 0, even mid-fill.
    if (clear) begin
      fill_active_d = 1'b1;
      fill_addr_d   = '0;
    end else begin
      fill_active_d = fill_active_d;
    end

    wr_ready_d = ~fill_active_d;
    busy_d     = (state_d != S_IDLE) | fill_active_d | dirty_d;
  end

  // Sequencer FSM: power-up wait, init commands, row/data refresh handshake.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    init_idx_d      = init_idx_q;
    row_d           = row_q;
    col_d           = col_q;
    lcd_req_d       = lcd_req_q;
    lcd_rs_d        = lcd_rs_q;
    lcd_byte_d      = lcd_byte_q;
    init_done_d     = init_done_q;
    refresh_start_s = 1'b0;

    // In every sending state: with req low, issue the byte; with req high,
    // hold everything until the ack, then drop req for at least one cycle.
    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_INIT;
          init_idx_d = 3'd0;
          lcd_req_d  = 1'b1;
          lcd_rs_d   = 1'b0;
          lcd_byte_d = init_cmd(3'd0);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_INIT: begin
        if (lcd_req_q) begin
          if (lcd_ack) begin
            lcd_req_d = 1'b0;
            if (init_idx_q == 3'd4) begin
              init_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              init_idx_d = init_idx_q + 3'd1;
            end
          end else begin
            lcd_req_d = 1'b1;
          end
        end else begin
          lcd_req_d  = 1'b1;
          lcd_rs_d   = 1'b0;
          lcd_byte_d = init_cmd(init_idx_q);
        end
      end
      S_IDLE: begin
        if (dirty_q && !fill_active_q) begin
          refresh_start_s = 1'b1;
          row_d           = 1'b0;
          state_d         = S_ROW_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROW_CMD: begin
        if (lcd_req_q) begin
          if (lcd_ack) begin
            lcd_req_d = 1'b0;
            col_d     = '0;
            state_d   = S_DATA;
          end else begin
            lcd_req_d = 1'b1;
          end
        end else begin
          lcd_req_d  = 1'b1;
          lcd_rs_d   = 1'b0;
          lcd_byte_d = row_q ? 8'hC0 : 8'h80;
        end
      end
      S_DATA: begin
        if (lcd_req_q) begin
          if (lcd_ack) begin
            lcd_req_d = 1'b0;
            if (col_q == LAST_COL) begin
              if (row_q) begin
                state_d = S_IDLE;
              end else begin
                row_d   = 1'b1;
                state_d = S_ROW_CMD;
              end
            end else begin
              col_d = col_q + AW'(1);
            end
          end else begin
            lcd_req_d = 1'b1;
          end
        end else begin
          lcd_req_d  = 1'b1;
          lcd_rs_d   = 1'b1;
          lcd_byte_d = mem_q[rd_addr_s];
        end
      end
      default: begin
        state_d   = S_PWR_WAIT;
        cnt_d     = '0;
        lcd_req_d = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset kicks off a fresh fill and power-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_active_q <= 1'b1;
      fill_addr_q   <= '0;
      cursor_q      <= '0;
      dirty_q       <= 1'b0;
      wr_ready_q    <= 1'b0;
      state_q       <= S_PWR_WAIT;
      cnt_q         <= '0;
      init_idx_q    <= 3'd0;
      row_q         <= 1'b0;
      col_q         <= '0;
      lcd_req_q     <= 1'b0;
      lcd_rs_q      <= 1'b0;
      lcd_byte_q    <= 8'h00;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      fill_active_q <= fill_active_d;
      fill_addr_q   <= fill_addr_d;
      cursor_q      <= cursor_d;
      dirty_q       <= dirty_d;
      wr_ready_q    <= wr_ready_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_idx_q    <= init_idx_d;
      row_q         <= row_d;
      col_q         <= col_d;
      lcd_req_q     <= lcd_req_d;
      lcd_rs_q      <= lcd_rs_d;
      lcd_byte_q    <= lcd_byte_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
    end
  end

  // Frame buffer storage; contents are defined by the fill that reset starts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Self-checking bench for lcd_text_sequencer (COLS = 16, INIT_DELAY = 100).
// An ack model answers each request after 3 cycles and logs {rs, byte}; the
// expected display stream is rebuilt from a plain array model of the buffer.
module tb_lcd_text_sequencer;

  localparam int COLS       = 16;
  localparam int INIT_DELAY = 100;
  localparam int DEPTH      = 2 * COLS;
  localparam int FRAME      = DEPTH + 2;
  localparam int ACK_LAT    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       clear;
  logic       lcd_req;
  logic       lcd_rs;
  logic [7:0] lcd_byte;
  logic       lcd_ack;
  logic       init_done;
  logic       busy;

  always #5 clk = ~clk;

  lcd_text_sequencer #(.COLS(COLS), .INIT_DELAY(INIT_DELAY)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char),
    .wr_ready(wr_ready), .clear(clear), .lcd_req(lcd_req), .lcd_rs(lcd_rs),
    .lcd_byte(lcd_byte), .lcd_ack(lcd_ack), .init_done(init_done), .busy(busy)
  );

  int         nvec = 0;
  int         nerr = 0;
  logic [8:0] log_q[$];
  logic [7:0] model [DEPTH];
  int         cur;
  bit         ack_en = 1'b1;
  int         acks_done = 0;

  typedef struct {
    logic [7:0] ch;
    int         addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_blank();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h20;
    cur = 0;
  endtask

  task automatic model_write(input logic [7:0] c);
    if (c == 8'h0A) begin
      cur = (cur < COLS) ? COLS : 0;
    end else begin
      model[cur] = c;
      cur = (cur + 1) % DEPTH;
    end
  endtask

  function automatic logic [8:0] exp_entry(input int i);
    if (i == 0) return {1'b0, 8'h80};
    else if (i <= COLS) return {1'b1, model[i-1]};
    else if (i == COLS + 1) return {1'b0, 8'hC0};
    else return {1'b1, model[i-2]};
  endfunction

  // Ack model, handshake stability and init_done tracking at posedge + 1.
  initial begin
    int         wait_cnt;
    logic [8:0] prev;
    bit         prev_valid;
    wait_cnt = 0; prev = 9'h000; prev_valid = 1'b0;
    lcd_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        lcd_ack = 1'b0; acks_done = 0; wait_cnt = 0; prev_valid = 1'b0;
      end else if (lcd_ack) begin
        lcd_ack = 1'b0;
        acks_done++;
        chk("req_low_after_ack", {31'd0, lcd_req}, 32'd0);
        prev_valid = 1'b0; wait_cnt = 0;
      end else begin
        chk("init_done", {31'd0, init_done}, (acks_done >= 5) ? 32'd1 : 32'd0);
        if (lcd_req) begin
          if (prev_valid) chk("req_hold_stable", {23'd0, lcd_rs, lcd_byte}, {23'd0, prev});
          prev = {lcd_rs, lcd_byte};
          prev_valid = 1'b1;
          wait_cnt++;
          if (ack_en && wait_cnt >= ACK_LAT) begin
            lcd_ack = 1'b1;
            log_q.push_back(prev);
          end
        end else begin
          prev_valid = 1'b0; wait_cnt = 0;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(busy == 1'b0 && lcd_req == 1'b0) && k < bound);
    chk("idle_reached", {31'd0, (busy == 1'b0 && lcd_req == 1'b0)}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] c);
    int k = 0;
    while (!wr_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_char = c;
    @(negedge clk);
    wr_valid = 1'b0;
    model_write(c);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_blank();
  endtask

  // The stream since mark must be whole refreshes; the last one shows the model.
  task automatic check_frame(input int mark);
    int n = log_q.size() - mark;
    int base = log_q.size() - FRAME;
    chk("refresh_len", {31'd0, (n >= FRAME && n % FRAME == 0)}, 32'd1);
    if (n >= FRAME) begin
      for (int i = 0; i < FRAME; i++) chk($sformatf("frame[%0d]", i), {23'd0, log_q[base+i]}, {23'd0, exp_entry(i)});
    end
  endtask

  // Counts cycles from reset release to first req; checks the init commands.
  task automatic powerup_check(input bit check_ready);
    logic [7:0] cmds [5];
    int cyc = 0, first_req = -1, first_rdy = -1, mark = log_q.size();
    cmds[0] = 8'h02; cmds[1] = 8'h28; cmds[2] = 8'h0C; cmds[3] = 8'h01; cmds[4] = 8'h06;
    while (cyc < 400 && first_req < 0) begin
      @(negedge clk);
      cyc++;
      if (wr_ready && first_rdy < 0) first_rdy = cyc;
      if (lcd_req) first_req = cyc;
    end
    chk("first_req_cycle", first_req, INIT_DELAY);
    if (check_ready) chk("wr_ready_rise_cycle", first_rdy, DEPTH);
    model_blank();
    wait_idle(3000);
    chk("powerup_bytes", log_q.size() - mark, 5 + FRAME);
    if (log_q.size() >= mark + 5 + FRAME) begin
      for (int i = 0; i < 5; i++) chk($sformatf("init_cmd[%0d]", i), {23'd0, log_q[mark+i]}, {23'd0, 1'b0, cmds[i]});
    end
    check_frame(mark + 5);
  endtask

  initial begin
    vec_t       tab [4];
    string      txt;
    int         mark, k, base;
    logic [8:0] held;

    tab[0] = '{8'h41, 0};
    tab[1] = '{8'h42, 1};
    tab[2] = '{8'h0A, -1};
    tab[3] = '{8'h43, 16};

    rst = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd_req", {31'd0, lcd_req}, 32'd0);
    chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_lcd_byte", {24'd0, lcd_byte}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    powerup_check(1'b1);

    // Text write.
    txt = "UEDB BY SIMS";
    mark = log_q.size();
    for (int i = 0; i < txt.len(); i++) do_write(txt[i]);
    wait_idle(3000);
    check_frame(mark);

    // Clear colliding with a write.
    clear = 1'b1; wr_valid = 1'b1; wr_char = 8'h51;
    #1;
    chk("wr_ready_low_with_clear", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    clear = 1'b0; wr_valid = 1'b0;
    model_blank();
    mark = log_q.size();
    k = 0;
    while (wr_ready == 1'b0 && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("fill_ready_low_cycles", k, DEPTH);
    wait_idle(3000);
    check_frame(mark);

    // Newline and wrap, table-driven.
    mark = log_q.size();
    for (int i = 0; i < 4; i++) do_write(tab[i].ch);
    wait_idle(3000);
    check_frame(mark);
    base = log_q.size() - FRAME;
    for (int i = 0; i < 4; i++) begin
      if (tab[i].addr >= 0)
        chk($sformatf("table_addr%0d", tab[i].addr), {23'd0, log_q[base + tab[i].addr + (tab[i].addr < COLS ? 1 : 2)]}, {23'd0, 1'b1, tab[i].ch});
    end
    mark = log_q.size();
    for (int i = 0; i < 31; i++) do_write(8'h78);
    wait_idle(6000);
    check_frame(mark);
    chk("wrap_keeps_C", {23'd0, log_q[log_q.size() - FRAME + 18]}, {23'd0, 1'b1, 8'h43});
    mark = log_q.size();
    do_write(8'h78);
    do_write(8'h0A);
    do_write(8'h4E);
    wait_idle(3000);
    check_frame(mark);
    chk("row1_newline_to_0", {23'd0, log_q[log_q.size() - FRAME + 1]}, {23'd0, 1'b1, 8'h4E});

    // Write during refresh.
    mark = log_q.size();
    do_write(8'h59);
    k = 0;
    while (log_q.size() - mark < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    do_write(8'h5A);
    wait_idle(6000);
    chk("two_refreshes", log_q.size() - mark, 2 * FRAME);
    check_frame(mark);

    // Ack withheld for 500 cycles.
    mark = log_q.size();
    ack_en = 1'b0;
    do_write(8'h48);
    k = 0;
    while (!lcd_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'd0, lcd_req}, 32'd1);
    held = {lcd_rs, lcd_byte};
    repeat (500) @(negedge clk);
    chk("req_held_500", {31'd0, lcd_req}, 32'd1);
    chk("byte_held_500", {23'd0, lcd_rs, lcd_byte}, {23'd0, held});
    ack_en = 1'b1;
    wait_idle(3000);
    check_frame(mark);

    // Randomized batches of writes, newlines and clears.
    for (int b = 0; b < 8; b++) begin
      mark = log_q.size();
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        int r = $urandom_range(0, 15);
        if (r == 0) do_clear();
        else if (r <= 2) do_write(8'h0A);
        else do_write(8'($urandom_range(32, 126)));
      end
      wait_idle(8000);
      check_frame(mark);
    end

    // Reset in the middle of a request.
    do_write(8'h52);
    k = 0;
    while (!(lcd_req && log_q.size() > mark + 2) && k < 500) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("req_drop_on_rst", {31'd0, lcd_req}, 32'd0);
    rst = 1'b0;
    powerup_check(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
